// File: rtl/modmul_pkg.sv
// Shared definitions for the modular-multiplier arbiter slice.
// Holds the field modulus, the default operand width and the tag-width helper.
package modmul_pkg;

  localparam int Q  = 3329;
  localparam int DW = 12;

  // Width of one tag entry: requester id bits plus one valid bit.
  function automatic int tag_w(input int num_req);
    return $clog2(num_req) + 1;
  endfunction

endpackage

// File: rtl/modmul_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first asserted request at or after ptr.
// Build option MODMUL_ARB_PRIO_EN: request 0 overrides the rotation and the
// rotation only covers requests 1..NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);

  logic [NUM_REQ-1:0] req_m;
  logic               prio_hit;
  logic               found;
  int                 idx;

  // Masked request vector: with the priority build, requester 0 is handled
  // outside the rotation.
  always_comb begin
`ifdef MODMUL_ARB_PRIO_EN
    req_m    = req;
    req_m[0] = 1'b0;
    prio_hit = req[0];
`else
    req_m    = req;
    prio_hit = 1'b0;
`endif
  end

  // Scan from the pointer, wrapping modulo NUM_REQ, and take the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (prio_hit) begin
      grant[0]  = 1'b1;
      grant_idx = '0;
      found     = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(ptr) + off;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end else begin
          idx = idx;
        end
        if (!found && req_m[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
          found      = 1'b1;
        end else begin
          found = found;
        end
      end
    end
    grant_any = found;
  end

endmodule

// File: rtl/modmul_arbiter.sv
// modmul_arbiter: shares one fixed-latency modular multiplier (q = 3329)
// between NUM_REQ requesters. One issue per cycle, round-robin grant, and a
// tag pipe that routes each result back to its requester MUL_LAT+1 cycles
// after the handshake.
// Build option MODMUL_ARB_PRIO_EN: requester 0 gets absolute priority and its
// grants leave the round-robin pointer untouched.
module modmul_arbiter
  import modmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = modmul_pkg::DW,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DW-1:0]         resp_r,
  output logic [DW-1:0]         mm_a,
  output logic [DW-1:0]         mm_b,
  input  logic [DW-1:0]         mm_r,
  output logic                  idle
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               handshake;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_nxt;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic [TW-1:0]      tag_pipe [0:MUL_LAT];
  logic [MUL_LAT:0]   tag_vld;
  logic [TW-1:0]      tag_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grant is suppressed while reset is held so nothing handshakes into a
  // pipe that is being cleared.
  always_comb begin
    if (rst) begin
      req_ready = '0;
      handshake = 1'b0;
    end else begin
      req_ready = grant;
      handshake = grant_any;
    end
  end

  // Next pointer: one past the granted requester, wrapping to 0.
  always_comb begin
    ptr_nxt = ptr;
    if (handshake) begin
`ifdef MODMUL_ARB_PRIO_EN
      if (grant_idx == IW'(0)) begin
        ptr_nxt = ptr;
      end else if (grant_idx == IW'(NUM_REQ - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = grant_idx + IW'(1);
      end
`else
      if (grant_idx == IW'(NUM_REQ - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = grant_idx + IW'(1);
      end
`endif
    end else begin
      ptr_nxt = ptr;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    sel_a = req_a[int'(grant_idx)*DW +: DW];
    sel_b = req_b[int'(grant_idx)*DW +: DW];
  end

  // Multiplier operand registers; hold their value when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_a <= '0;
      mm_b <= '0;
    end else if (handshake) begin
      mm_a <= sel_a;
      mm_b <= sel_b;
    end else begin
      mm_a <= mm_a;
      mm_b <= mm_b;
    end
  end

  // Tag shift register: entry k is the op issued k+1 cycles ago; never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (handshake) begin
        tag_pipe[0] <= {1'b1, grant_idx};
      end else begin
        tag_pipe[0] <= '0;
      end
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Collect tag valid bits for the idle indication.
  always_comb begin
    tag_vld = '0;
    for (int i = 0; i <= MUL_LAT; i++) begin
      tag_vld[i] = tag_pipe[i][TW-1];
    end
  end

  // Response decode from the oldest tag; the result is the multiplier output.
  always_comb begin
    tag_last   = tag_pipe[MUL_LAT];
    resp_valid = '0;
    if (tag_last[TW-1]) begin
      resp_valid[tag_last[IW-1:0]] = 1'b1;
    end else begin
      resp_valid = '0;
    end
    resp_r = mm_r;
  end

  // Idle when nothing is requested and nothing is in flight.
  always_comb begin
    idle = ~|req_valid & ~|tag_vld;
  end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: directed vectors, scoreboard queue of expected
// responses, and an independent monitor that checks every resp_valid.
// Build with +define+MODMUL_ARB_PRIO_EN to exercise the priority variant.
module tb_modmul_arbiter;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_r;
  logic [W-1:0]   mm_a;
  logic [W-1:0]   mm_b;
  logic [W-1:0]   mm_r;
  logic           idle;

  logic [W-1:0]   p1;
  logic [W-1:0]   p2;

  typedef struct {
    int id;
    int r;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  modmul_arbiter #(.NUM_REQ(N), .DW(W), .MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_r     (resp_r),
    .mm_a       (mm_a),
    .mm_b       (mm_b),
    .mm_r       (mm_r),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Cycle counter used for response due times.
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage multiplier model (a*b mod 3329).
  always @(posedge clk) begin
    p1 <= W'((32'(mm_a) * 32'(mm_b)) % 3329);
    p2 <= p1;
  end
  assign mm_r = p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the head of the queue, on time.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL resp_missing: id %0d due cycle %0d, still outstanding at cycle %0d", e.id, e.due, cyc);
    end
    if (resp_valid != '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: resp_valid=%b resp_r=%0d, nothing expected", resp_valid, resp_r);
      end else begin
        e = exp_q.pop_front();
        if (resp_valid !== N'(1 << e.id) || resp_r !== W'(e.r) || e.due != cyc) begin
          fails++;
          $display("FAIL resp: got valid=%b r=%0d at cycle %0d, expected id %0d r=%0d at cycle %0d",
                   resp_valid, resp_r, cyc, e.id, e.r, e.due);
        end
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // One cycle of stimulus: check the grant, queue the expected response.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] eg, input int er, input bit push);
    req_valid = v;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(eg));
    if (push && eg != '0) begin
      for (int i = 0; i < N; i++) begin
        if (eg[i]) exp_q.push_back('{id: i, r: er, due: cyc + 1 + LAT});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_mm_a", 32'(mm_a), 32'd0);
    chk("rst_mm_b", 32'(mm_b), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk);
    #1;
    // Test 1: reset and idle
    do_reset();
    @(negedge clk);
    chk("idle_after_rst", 32'(idle), 32'd1);
    chk("ready_no_req", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;

    // Test 2: single op 17*200 mod 3329 = 71
    set_op(0, 17, 200);
    step(4'b0001, 4'b0001, 71, 1'b1);
    req_valid = '0;
    @(negedge clk);
    chk("mm_a_issue", 32'(mm_a), 32'd17);
    chk("mm_b_issue", 32'(mm_b), 32'd200);
    chk("busy_inflight", 32'(idle), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mm_a_hold", 32'(mm_a), 32'd17);
    @(posedge clk);
    #1;
    idle_cycles(4);
    @(negedge clk);
    chk("idle_drained", 32'(idle), 32'd1);
    @(posedge clk);
    #1;

    // Operands: 2*3=6, 1000*4=671, 3328*2=3327, 50*70=171 (mod 3329)
    set_op(0, 2, 3);
    set_op(1, 1000, 4);
    set_op(2, 3328, 2);
    set_op(3, 50, 70);

`ifdef MODMUL_ARB_PRIO_EN
    // Test 6: requester 0 always wins, pointer stays at 0
    do_reset();
    repeat (4) step(4'b1111, 4'b0001, 6, 1'b1);
    step(4'b1110, 4'b0010, 671, 1'b1);
    step(4'b1110, 4'b0100, 3327, 1'b1);
    step(4'b1110, 4'b1000, 171, 1'b1);
    step(4'b1110, 4'b0010, 671, 1'b1);
    idle_cycles(5);
`else
    // Test 3: round-robin with pointer 0, all four valid
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(4'b1111, 4'b0001, 6, 1'b1);
      step(4'b1111, 4'b0010, 671, 1'b1);
      step(4'b1111, 4'b0100, 3327, 1'b1);
      step(4'b1111, 4'b1000, 171, 1'b1);
    end
    idle_cycles(5);

    // Test 4: get pointer to 3, then wrap and skip with 4'b0101
    step(4'b0100, 4'b0100, 3327, 1'b1);
    step(4'b0101, 4'b0001, 6, 1'b1);
    step(4'b0101, 4'b0100, 3327, 1'b1);
    idle_cycles(5);

    // Test 5: three ops in flight, reset the next cycle -> none may return
    step(4'b0111, 4'b0001, 0, 1'b0);
    step(4'b0111, 4'b0010, 0, 1'b0);
    step(4'b0111, 4'b0100, 0, 1'b0);
    do_reset();
    idle_cycles(6);
    set_op(0, 3328, 3328);
    step(4'b0001, 4'b0001, 1, 1'b1);
    idle_cycles(5);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
